// File: rtl/res_port_reader.sv
// rtl/res_port_reader.sv - result bank read-back DMA streaming paired bank words as 256-bit beats
//
// Sweeps the result SRAM banks in interleaved order (bank = h mod BANKS,
// address = base + h / BANKS), captures the returned 128-bit words into a
// small FIFO and emits them in pairs {odd word, even word} on a valid/ready
// output. Reads are credit-limited so the FIFO can never overflow even with
// the consumer stalled.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             one-cycle start pulse (honoured only when idle)
//   tran_time         number of 256-bit beats, sampled with start
//   base_addr         first bank word address, sampled with start
//   busy, done        transfer in progress / one-cycle completion pulse
//   bce, braddr       one-hot bank read enable and shared read address
//   brdata, brvalid   concatenated bank read data and per-bank data valid
//   dout, dout_valid, dout_ready   output beat stream

module res_port_reader #(
  parameter int BANKS       = 8,
  parameter int ADDR_W      = 15,
  parameter int BW          = 128,
  parameter int FIFO_HALVES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [12:0]           tran_time,
  input  logic [ADDR_W-1:0]     base_addr,
  output logic                  busy,
  output logic                  done,
  output logic [BANKS-1:0]      bce,
  output logic [ADDR_W-1:0]     braddr,
  input  logic [BANKS*BW-1:0]   brdata,
  input  logic [BANKS-1:0]      brvalid,
  output logic [2*BW-1:0]       dout,
  output logic                  dout_valid,
  input  logic                  dout_ready
);

  localparam int PTR_W  = $clog2(FIFO_HALVES);
  localparam int CNT_W  = $clog2(FIFO_HALVES + 1);
  localparam int BSEL_W = $clog2(BANKS);
  localparam logic [CNT_W-1:0] TWO  = CNT_W'(2);
  localparam logic [CNT_W-1:0] FH_C = CNT_W'(FIFO_HALVES);
  localparam logic [BANKS-1:0] BANK0 = {{(BANKS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             state;
  logic [12:0]        tt_q;
  logic [ADDR_W-1:0]  base_q;
  logic [13:0]        h_q;        // halves issued so far (cycles with bce already completed)
  logic [12:0]        beat_q;     // beats handshaken so far
  logic [CNT_W-1:0]   credit_q;   // issued reads not yet popped (in flight + stored)
  logic [CNT_W-1:0]   fcount_q;   // words stored in the FIFO
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   rd_ptr_p1;
  logic [BW-1:0]      mem [FIFO_HALVES];

  logic               issue;
  logic               pop;
  logic               push;
  logic [BW-1:0]      cap_word;
  logic [13:0]        h_nx;
  logic [12:0]        beat_nx;
  logic [CNT_W-1:0]   credit_nx;
  logic [ADDR_W-1:0]  next_addr;
  logic [BANKS-1:0]   next_oh;

  assign issue      = |bce;
  assign dout_valid = (fcount_q >= TWO);
  assign pop        = dout_valid & dout_ready;
  // Late read data after a reset or abort lands while idle and is dropped.
  assign push       = (|brvalid) && (state != S_IDLE);
  assign rd_ptr_p1  = rd_ptr + 1'b1;
  assign dout       = dout_valid ? {mem[rd_ptr_p1], mem[rd_ptr]} : '0;

  // Values as they will stand after this edge; the next read is decided
  // from them so bce/braddr can be registered without losing a cycle.
  assign h_nx      = h_q + 14'(issue);
  assign beat_nx   = beat_q + 13'(pop);
  assign credit_nx = credit_q + CNT_W'(issue) - (pop ? TWO : '0);
  assign next_addr = base_q + ADDR_W'(h_nx >> BSEL_W);
  assign next_oh   = BANK0 << h_nx[BSEL_W-1:0];

  always_comb begin
    cap_word = '0;
    for (int i = 0; i < BANKS; i++) begin
      if (brvalid[i]) cap_word = brdata[i*BW +: BW];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cap_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      tt_q     <= '0;
      base_q   <= '0;
      h_q      <= '0;
      beat_q   <= '0;
      credit_q <= '0;
      fcount_q <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bce      <= '0;
      braddr   <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        fcount_q <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(2);
        fcount_q <= fcount_q + CNT_W'(push) - (pop ? TWO : '0);
      end

      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            tt_q     <= tran_time;
            base_q   <= base_addr;
            h_q      <= '0;
            beat_q   <= '0;
            credit_q <= '0;
            if (tran_time == 13'd0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state  <= S_RUN;
              busy   <= 1'b1;
              bce    <= BANK0;
              braddr <= base_addr;
            end
          end
        end

        S_RUN: begin
          h_q      <= h_nx;
          beat_q   <= beat_nx;
          credit_q <= credit_nx;
          if (h_nx == {tt_q, 1'b0}) begin
            state  <= S_DRAIN;
            bce    <= '0;
            braddr <= '0;
          end else if (credit_nx < FH_C) begin
            bce    <= next_oh;
            braddr <= next_addr;
          end else begin
            bce    <= '0;
            braddr <= '0;
          end
        end

        S_DRAIN: begin
          beat_q   <= beat_nx;
          credit_q <= credit_nx;
          if (pop && beat_nx == tt_q) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // The banks answer only the single enabled bank, so two valids at once
  // means the wrapper is misbehaving.
  a_brvalid_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(brvalid));

endmodule

// File: tb/tb_res_port_reader.sv
// tb/tb_res_port_reader.sv - self-checking bench for res_port_reader

module tb_res_port_reader;

  localparam int BANKS = 8;
  localparam int BW    = 128;
  localparam int FH    = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [12:0]          tran_time;
  logic [14:0]          base_addr;
  logic                 busy;
  logic                 done;
  logic [BANKS-1:0]     bce;
  logic [14:0]          braddr;
  logic [BANKS*BW-1:0]  brdata;
  logic [BANKS-1:0]     brvalid;
  logic [255:0]         dout;
  logic                 dout_valid;
  logic                 dout_ready;

  res_port_reader dut (
    .clk(clk), .rst(rst), .start(start), .tran_time(tran_time), .base_addr(base_addr),
    .busy(busy), .done(done), .bce(bce), .braddr(braddr), .brdata(brdata),
    .brvalid(brvalid), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model / monitor state
  int          cyc;
  int          m_tt;
  logic [14:0] m_base;
  logic [31:0] salt;
  int          lat;
  int          rmode;      // 0: ready=1, 1: ready=0, 2: random
  bit          active;
  int rd_idx, beats, last_hs, first_hs, resume_cyc, done_cyc, first_valid, done_pulses;
  int busy_bad, oh_bad, order_bad, credit_bad, hold_bad, at7fff, at0;
  bit          holding;
  logic [255:0] held;
  logic [BANKS-1:0] bce_at [0:15];
  logic [BANKS-1:0] st_bce [0:5];
  logic [14:0]      st_addr [0:5];

  typedef struct {
    int tt;
    int base;
    int lat;
    int rmode;
    int exp_reads;
    int exp_beats;
  } vec_t;
  vec_t vecs [0:9];

  task automatic check(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] word_of(int bank, logic [14:0] a, logic [31:0] s);
    return {s, 32'(bank), {17'd0, a}, s ^ {17'd0, a} ^ (32'(bank) * 32'h01010101)};
  endfunction

  function automatic logic [14:0] addr_of(int h);
    return 15'((int'(m_base) + h / 8) % 32768);
  endfunction

  function automatic logic [255:0] beat_of(int k);
    return {word_of((2*k+1) % 8, addr_of(2*k+1), salt), word_of((2*k) % 8, addr_of(2*k), salt)};
  endfunction

  // One clock: bank responder, ready driver, then monitor of this cycle.
  task automatic tick();
    @(negedge clk);
    cyc++;
    for (int k = 5; k > 0; k--) begin
      st_bce[k]  = st_bce[k-1];
      st_addr[k] = st_addr[k-1];
    end
    st_bce[0]  = bce;
    st_addr[0] = braddr;
    brvalid = st_bce[lat];
    for (int i = 0; i < BANKS; i++) brdata[i*BW +: BW] = word_of(i, st_addr[lat], salt);
    case (rmode)
      0:       dout_ready = 1'b1;
      1:       dout_ready = 1'b0;
      default: dout_ready = 1'($urandom_range(0, 1));
    endcase
    if (active) begin
      if (cyc < 16) bce_at[cyc] = bce;
      if (bce != '0) begin
        if (!$onehot(bce)) oh_bad++;
        else if (bce != (8'b1 << (rd_idx % 8)) || braddr != addr_of(rd_idx)) order_bad++;
        if (braddr == 15'h7fff) at7fff++;
        if (braddr == 15'h0000) at0++;
        if (first_hs >= 0 && resume_cyc < 0) resume_cyc = cyc;
        rd_idx++;
      end
      if (rd_idx - 2*beats > FH) credit_bad++;
      if (holding && (!dout_valid || dout !== held)) hold_bad++;
      holding = 1'b0;
      if (dout_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (dout_ready) begin
          check($sformatf("beat%0d", beats), dout, beat_of(beats));
          beats++;
          last_hs = cyc;
          if (first_hs < 0) first_hs = cyc;
        end else begin
          holding = 1'b1;
          held = dout;
        end
      end
      if (done) begin
        done_pulses++;
        if (done_cyc < 0) done_cyc = cyc;
        if (busy) busy_bad++;
      end else if (done_cyc < 0 && m_tt > 0 && !busy) busy_bad++;
      else if (done_cyc >= 0 && busy) busy_bad++;
    end
  endtask

  task automatic idle(int n);
    active = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_xfer(int tt, int base);
    tran_time = 13'(tt);
    base_addr = 15'(base);
    start = 1'b1;
    m_tt = tt; m_base = 15'(base);
    rd_idx = 0; beats = 0; last_hs = -1; first_hs = -1; resume_cyc = -1;
    done_cyc = -1; first_valid = -1; done_pulses = 0;
    busy_bad = 0; oh_bad = 0; order_bad = 0; credit_bad = 0; hold_bad = 0;
    at7fff = 0; at0 = 0; holding = 1'b0;
    for (int i = 0; i < 16; i++) bce_at[i] = '0;
    cyc = 0;
    active = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_until_done(int bound);
    while (done_cyc < 0 && cyc < bound) tick();
    tick();
    tick();
    check("done_seen", 256'(done_cyc >= 0), 256'(1));
  endtask

  task automatic finish_checks(string n, int exp_reads, int exp_beats);
    check({n, " reads"}, 256'(rd_idx), 256'(exp_reads));
    check({n, " beats"}, 256'(beats), 256'(exp_beats));
    check({n, " done_pulses"}, 256'(done_pulses), 256'(1));
    check({n, " busy"}, 256'(busy_bad), 256'(0));
    check({n, " onehot"}, 256'(oh_bad), 256'(0));
    check({n, " order"}, 256'(order_bad), 256'(0));
    check({n, " credit"}, 256'(credit_bad), 256'(0));
    check({n, " hold"}, 256'(hold_bad), 256'(0));
    if (exp_beats > 0) check({n, " done_after_hs"}, 256'(done_cyc), 256'(last_hs + 1));
  endtask

  initial begin
    logic [7:0] exp_bce [0:4];
    int late_bad;

    rst = 1'b1; start = 1'b0; tran_time = '0; base_addr = '0;
    brvalid = '0; brdata = '0; dout_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin st_bce[k] = '0; st_addr[k] = '0; end
    salt = 32'h1111_0001; lat = 1; rmode = 0; active = 1'b0; cyc = 0; m_tt = 0; m_base = '0;
    holding = 1'b0; held = '0;

    // Reset state
    idle(6);
    check("rst busy", 256'(busy), 256'(0));
    check("rst done", 256'(done), 256'(0));
    check("rst bce", 256'(bce), 256'(0));
    check("rst braddr", 256'(braddr), 256'(0));
    check("rst dout", dout, 256'(0));
    check("rst dout_valid", 256'(dout_valid), 256'(0));
    rst = 1'b0;
    idle(5);

    // Basic two-beat transfer, exact timing
    salt = 32'hA5A5_0002; lat = 1; rmode = 0;
    start_xfer(2, 0);
    run_until_done(100);
    exp_bce = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08};
    for (int i = 1; i <= 4; i++) check($sformatf("basic bce@%0d", i), 256'(bce_at[i]), 256'(exp_bce[i]));
    check("basic bce@5", 256'(bce_at[5]), 256'(0));
    check("basic first_valid", 256'(first_valid), 256'(4));
    check("basic done_cyc", 256'(done_cyc), 256'(7));
    finish_checks("basic", 4, 2);
    idle(6);

    // Consumer stalled: issue must stop after FIFO_HALVES words
    salt = 32'h5EED_0003; lat = 2; rmode = 1;
    start_xfer(8, 15'h0123);
    for (int i = 0; i < 25; i++) tick();
    check("stall reads", 256'(rd_idx), 256'(FH));
    check("stall bce", 256'(bce), 256'(0));
    rmode = 0;
    run_until_done(300);
    check("stall resume", 256'(resume_cyc), 256'(first_hs + 1));
    finish_checks("stall", 16, 8);
    idle(6);

    // Zero-length transfer
    rmode = 0; lat = 1;
    start_xfer(0, 5);
    run_until_done(20);
    check("zero done_cyc", 256'(done_cyc), 256'(1));
    check("zero first_valid", 256'(first_valid), 256'(-1));
    finish_checks("zero", 0, 0);
    idle(6);

    // Address wrap at the top of the bank
    salt = 32'h0F0F_0004; lat = 1; rmode = 2;
    start_xfer(8, 15'h7FFF);
    run_until_done(400);
    check("wrap at7fff", 256'(at7fff), 256'(8));
    check("wrap at0", 256'(at0), 256'(8));
    finish_checks("wrap", 16, 8);
    idle(6);

    // Reset mid-transfer with reads in flight
    salt = 32'hDEAD_0005; lat = 3; rmode = 2;
    start_xfer(20, 100);
    for (int i = 0; i < 10; i++) tick();
    active = 1'b0;
    rst = 1'b1;
    tick();
    check("midrst busy", 256'(busy), 256'(0));
    check("midrst done", 256'(done), 256'(0));
    check("midrst bce", 256'(bce), 256'(0));
    check("midrst braddr", 256'(braddr), 256'(0));
    check("midrst dout", dout, 256'(0));
    check("midrst dout_valid", 256'(dout_valid), 256'(0));
    rst = 1'b0;
    late_bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (dout_valid || busy || bce != '0) late_bad++;
    end
    check("midrst late", 256'(late_bad), 256'(0));
    salt = 32'hBEEF_0006; lat = 1; rmode = 0;
    start_xfer(6, 200);
    run_until_done(200);
    finish_checks("after_rst", 12, 6);
    idle(6);

    // start re-pulsed while busy is ignored
    salt = 32'hCAFE_0007; lat = 2; rmode = 2;
    start_xfer(5, 300);
    for (int i = 0; i < 4; i++) tick();
    start = 1'b1; tran_time = 13'd9; base_addr = 15'd7;
    tick();
    start = 1'b0;
    run_until_done(300);
    finish_checks("repulse", 10, 5);
    idle(6);

    // Table-driven randomized transfers
    vecs[0] = '{1, 0, 1, 0, 2, 1};
    vecs[1] = '{3, 32760, 4, 2, 6, 3};
    vecs[2] = '{12, 1000, 2, 2, 24, 12};
    for (int i = 3; i < 10; i++) begin
      vecs[i].tt    = $urandom_range(1, 12);
      vecs[i].base  = $urandom_range(0, 32767);
      vecs[i].lat   = $urandom_range(1, 4);
      vecs[i].rmode = 2;
      vecs[i].exp_reads = 2 * vecs[i].tt;
      vecs[i].exp_beats = vecs[i].tt;
    end
    for (int i = 0; i < 10; i++) begin
      salt  = $urandom;
      lat   = vecs[i].lat;
      rmode = vecs[i].rmode;
      start_xfer(vecs[i].tt, vecs[i].base);
      run_until_done(60 * vecs[i].tt + 60);
      finish_checks($sformatf("vec%0d", i), vecs[i].exp_reads, vecs[i].exp_beats);
      idle(6);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/res_port_reader.md
# res_port_reader

Result read-back DMA for the TPU datapath: the read-side counterpart of the activation/weight port writer. After the compute core has written results into the eight result SRAM banks, this block sweeps those banks in a fixed interleaved order, pairs 128-bit bank words into 256-bit beats, and streams them out over a valid/ready bus to the host-side data path. It sits between the result-bank read ports of the 16-bank SRAM wrapper and the top-level output bus, and is started by the top-level FSM's `res_port_start` pulse.

## Interface
- `BANKS`, 8: number of result banks swept; bank index 0 maps to wrapper bank 8.
- `ADDR_W`, 15: bank word address width.
- `BW`, 128: bank read word width (lower half of wrapper read data).
- `FIFO_HALVES`, 8: output buffer capacity in 128-bit words (4 beats); also the maximum number of in-flight reads plus stored words.
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: one-cycle start pulse; sampled only in IDLE.
- `tran_time` in 13: number of 256-bit beats to deliver; sampled with `start`.
- `base_addr` in ADDR_W: first word address; sampled with `start`.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle completion pulse.
- `bce` out BANKS: one-hot per-bank read enable.
- `braddr` out ADDR_W: read address shared by all banks, valid when any `bce` bit is set.
- `brdata` in BANKS*BW: concatenated bank read data, bank i at [i*BW +: BW].
- `brvalid` in BANKS: per-bank read-data valid, fixed latency L≥1 after `bce`.
- `dout` out 256: output beat.
- `dout_valid` out 1: beat valid.
- `dout_ready` in 1: consumer ready.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: `start`=1 latches `tran_time`, `base_addr`; clears counters; goes to RUN, or to DONE if `tran_time`=0. `start` in any other state is ignored.
- Word order: half index h = 0 .. 2*tran_time-1; bank = h mod BANKS; address = (base_addr + h/BANKS) mod 2^ADDR_W (wraps 0x7FFF -> 0x0000).
- RUN: issues one read (one-hot `bce`, `braddr`) per cycle when credit < FIFO_HALVES; credit = issued-but-not-popped words. RUN -> DRAIN when the last half is issued.
- Capture: when any `brvalid` bit is set, the selected bank's `brdata` slice is pushed to the FIFO. More than one `brvalid` bit set in a cycle is a protocol violation (assert).
- Beat k = {word 2k+1, word 2k}: the even word occupies the low 128 bits.
- Output: `dout_valid`=1 when ≥2 words are stored; pop of 2 words on `dout_valid & dout_ready`. `dout` is held stable while `dout_valid` & !`dout_ready`.
- Credit: +1 on issue, -2 on pop, net in the same cycle. It never exceeds FIFO_HALVES.
- DRAIN -> DONE when all beats have been handshaken. DONE drives `done`=1 for one cycle and then goes to IDLE.
- `brvalid` arriving in IDLE is discarded.
- Reset (including mid-transfer): state to IDLE; counters and FIFO cleared; all outputs 0 (`busy`, `done`, `bce`, `braddr`, `dout`, `dout_valid`).

## Timing
- `start` at cycle 0 -> `busy`=1 and first `bce` at cycle 1.
- Full-rate issue: one word per cycle; sustained throughput is one beat per 2 cycles with `dout_ready`=1.
- Word captured at cycle t -> visible in the FIFO at t+1. `dout_valid` rises the cycle after the second word of a pair is captured.
- The last handshake at cycle t gives `done`=1 and `busy`=0 at t+1.
- `tran_time`=0: `done` at cycle 1, `bce` never asserted.
- With `dout_ready`=0, issue stalls after FIFO_HALVES words; it resumes the cycle after a pop.

## Test plan
- tran_time=2, base_addr=0, L=1, bank i word a = {i,a}, `dout_ready`=1 -> `bce` one-hot 0,1,2,3 at cycles 1-4, `braddr`=0; beats {bank1,bank0}, {bank3,bank2}; `done` one cycle after the second handshake.
- tran_time=8, `dout_ready`=0 -> exactly 8 reads issued, then `bce`=0; raising `dout_ready` gives all 8 beats in order with no loss or duplication, and issue resumes.
- tran_time=0 -> `done` pulse at cycle 1; `bce`, `dout_valid` never high.
- base_addr=0x7FFF, tran_time=8 -> words 0-7 read at 0x7FFF, words 8-15 at 0x0000.
- `rst` asserted mid-RUN with reads in flight -> next cycle all outputs 0; late `brvalid` ignored; a new `start` runs a clean transfer.
- `start` re-pulsed while `busy` -> ignored; beat count and order unchanged.
